// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// Module   : uart_pkg
// Desc     : Shared frame constants, FSM encoding and timing helper for UART blocks
// Revision : 1.0
//==============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    // Counter value at the centre of the start bit.
    function automatic int mid_count(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
//==============================================================================
// Module   : sync_2ff
// Desc     : Two-flop synchronizer for a single asynchronous input bit
// Revision : 1.0
//==============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx
// Desc     : 8N1 serial receiver delivering bytes over a valid/ready handshake
// Revision : 1.0
//==============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    localparam int              c_cw   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_mid  = c_cw'(mid_count(CLKS_PER_BIT));
    localparam logic [2:0]      c_lastbit = 3'(DATA_BITS - 1);

    logic                          w_rx;
    logic [2:0]                    r_state;
    logic [c_cw-1:0]               r_cnt;
    logic [2:0]                    r_bit;
    logic [uart_pkg::DATA_BITS-1:0] r_shift;
    logic [7:0]                    r_data;
    logic                          r_valid;
    logic                          r_busy;
    logic                          r_ferr;
    logic                          r_ovr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (!w_rx) begin
                        r_state <= c_st_start;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (r_cnt == c_mid) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        if (w_rx) begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[uart_pkg::DATA_BITS-1:1]};
                        if (r_bit == c_lastbit) begin
                            r_state <= c_st_stop;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    if (r_cnt == c_last) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                        if (w_rx) begin
                            r_state <= c_st_idle;
                            // A consume in this same cycle frees the holding register.
                            if (!r_valid || ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= c_st_break;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_break: begin
                    if (w_rx) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx
// Desc     : Self-checking bench for uart_rx: vector table, corner sequences, random frames
// Revision : 1.0
//==============================================================================
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Observation state filled by the monitor
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         hold_viol = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (prev_hold && data !== prev_data) hold_viol++;
            prev_hold = valid && !ready;
            prev_data = data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        logic [7:0] v;
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL %s actual=none required=%0h", name, exp);
        end else begin
            v = got_q.pop_front();
            if (v !== exp) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", name, v, exp);
            end
        end
    endtask

    // All line tasks start and end 1 ns after a rising edge.
    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stopb);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stopb;
        int         gap;
        logic       exp_byte;
        logic       exp_fe;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] exp_q[$];
    int         fe0, ov0, lat, bc, n_fe_exp;
    logic [7:0] rb;
    logic       rs;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 2, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b0, 4, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 0, 1'b1, 1'b0};
        tbl[5] = '{8'h55, 1'b1, 0, 1'b1, 1'b0};
        tbl[6] = '{8'hAA, 1'b1, 3, 1'b1, 1'b0};
        tbl[7] = '{8'h7E, 1'b0, 5, 1'b0, 1'b1};

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", data, 8'h00);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_flags", {frame_err, overrun}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte latency and one-cycle valid pulse
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                lat = 0;
                do begin
                    @(posedge clk);
                    #2;
                    lat++;
                end while (!valid && lat < 400);
                chk("latency_edges", lat, 154);
                chk("latency_data", data, 8'hA5);
                @(posedge clk);
                #2;
                chk("latency_valid_pulse", valid, 0);
            end
        join
        idle(2);
        expect_byte("latency_byte", 8'hA5);
        chk("latency_no_flags", fe_cnt + ov_cnt, 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            fe0 = fe_cnt;
            send_frame(tbl[i].b, tbl[i].stopb);
            idle(tbl[i].gap);
            if (tbl[i].exp_byte) expect_byte("tbl_byte", tbl[i].b);
            else chk("tbl_no_byte", got_q.size(), 0);
            chk("tbl_frame_err", fe_cnt - fe0, int'(tbl[i].exp_fe));
        end

        // Glitch shorter than half a bit
        idle(4);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                rxd = 1'b1;
            end
            begin
                bc = 0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #2;
                    if (busy) bc++;
                end
            end
        join
        checks++;
        if (bc < C / 2 || bc > C / 2 + 1) begin
            errors++;
            $display("FAIL glitch_busy_cycles actual=%0d required=%0d..%0d", bc, C / 2, C / 2 + 1);
        end
        chk("glitch_busy_end", busy, 0);
        chk("glitch_no_byte", got_q.size(), 0);
        chk("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        idle(1);
        send_frame(8'h3C, 1'b1);
        idle(2);
        expect_byte("glitch_next", 8'h3C);

        // Framing error followed by a held-low line
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("ferr_once", fe_cnt - fe0, 1);
        chk("ferr_valid", valid, 0);
        chk("ferr_no_byte", got_q.size(), 0);
        idle(4);
        send_frame(8'h81, 1'b1);
        idle(2);
        expect_byte("ferr_recover", 8'h81);
        chk("ferr_no_more", fe_cnt - fe0, 1);

        // Backpressure and overrun
        ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2);
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_pulse", ov_cnt - ov0, 1);
        ready = 1'b1;
        @(posedge clk);
        #2;
        chk("ovr_drop_valid", valid, 0);
        expect_byte("ovr_byte", 8'h11);
        chk("ovr_no_extra", got_q.size(), 0);
        idle(2);

        // Consume and load in the same cycle
        ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                #1;
                ready = 1'b1;
                @(posedge clk);
                #2;
                chk("simul_valid", valid, 1);
                chk("simul_data", data, 8'h22);
                ready = 1'b0;
            end
        join
        chk("simul_no_ovr", ov_cnt - ov0, 0);
        expect_byte("simul_first", 8'h11);
        idle(2);
        ready = 1'b1;
        idle(2);
        expect_byte("simul_second", 8'h22);
        chk("simul_drained", valid, 0);

        // Asynchronous reset during data bit 4
        fe0 = fe_cnt;
        fork
            send_frame(8'hF3, 1'b1);
            begin
                @(posedge clk);
                repeat (70) @(posedge clk);
                #1;
                chk("rst_busy_before", busy, 1);
                rst = 1'b1;
                #1;
                chk("rst_async_outputs", {data, valid, busy, frame_err, overrun}, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        idle(4);
        chk("rst_no_byte", got_q.size(), 0);
        chk("rst_no_ferr", fe_cnt - fe0, 0);
        send_frame(8'h5A, 1'b1);
        idle(2);
        expect_byte("rst_next", 8'h5A);

        // Random frames against a queue model
        fe0 = fe_cnt;
        n_fe_exp = 0;
        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            if (rs) begin
                exp_q.push_back(rb);
                idle($urandom_range(0, 2));
            end else begin
                n_fe_exp++;
                idle(3);
            end
        end
        idle(4);
        chk("rand_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0) expect_byte("rand_byte", exp_q.pop_front());
        chk("rand_frame_err", fe_cnt - fe0, n_fe_exp);

        chk("data_hold_stable", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
